// File: rtl/reg_file_sb.sv
// Parametrised register file with write-to-read bypass and a per-register pending-write
// scoreboard for pipeline stall logic. Define REG_FILE_ZERO_REG_EN to hardwire register 0 to zero.
module reg_file_sb #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       NUM_REGS  = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int unsigned      AW        = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [AW-1:0]     r_write_enc,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     r_enc_0,
  input  logic [AW-1:0]     r_enc_1,
  output logic [DATA_W-1:0] reg_out_0,
  output logic [DATA_W-1:0] reg_out_1,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_enc,
  output logic              hazard_0,
  output logic              hazard_1,
  output logic [AW:0]       pending_cnt,
  output logic [DATA_W-1:0] R0_val,
  output logic [DATA_W-1:0] R1_val
);

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [AW:0]         pending_cnt_q, pending_cnt_d;

  logic wr_en;
  logic set_en;

  // With the zero register enabled, enc 0 neither stores data nor tracks a producer.
  assign wr_en  = we && !(ZeroReg && (r_write_enc == '0));
  assign set_en = issue_valid && !(ZeroReg && (issue_enc == '0));

  // Clear first so a same-cycle issue to the retiring register keeps the bit set.
  always_comb begin
    pending_d = pending_q;
    if (wr_en) begin
      pending_d[r_write_enc] = 1'b0;
    end
    if (set_en) begin
      pending_d[issue_enc] = 1'b1;
    end
  end

  always_comb begin
    pending_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pending_cnt_d = pending_cnt_d + {{AW{1'b0}}, pending_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      pending_q     <= '0;
      pending_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[r_write_enc] <= wdata;
      end
      pending_q     <= pending_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  logic [AW-1:0]     rd_enc    [2];
  logic [DATA_W-1:0] rd_data   [2];
  logic [1:0]        rd_hit;
  logic [1:0]        rd_hazard;

  assign rd_enc[0] = r_enc_0;
  assign rd_enc[1] = r_enc_1;
  assign rd_hit[0] = we && (r_write_enc == r_enc_0);
  assign rd_hit[1] = we && (r_write_enc == r_enc_1);

  // A retiring write is forwarded, so it never counts as a hazard on its own register.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p]   = rd_hit[p] ? wdata : regs_q[rd_enc[p]];
      rd_hazard[p] = pending_q[rd_enc[p]] && !rd_hit[p];
      if (ZeroReg && (rd_enc[p] == '0)) begin
        rd_data[p]   = '0;
        rd_hazard[p] = 1'b0;
      end
    end
  end

  assign reg_out_0   = rd_data[0];
  assign reg_out_1   = rd_data[1];
  assign hazard_0    = rd_hazard[0];
  assign hazard_1    = rd_hazard[1];
  assign pending_cnt = pending_cnt_q;
  assign R0_val      = ZeroReg ? '0 : regs_q[0];
  assign R1_val      = regs_q[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a default 4x32 instance and an 8x16 instance (reset value 3) checked
// every cycle against an array-based model, plus hand-computed literal checks.
module tb_reg_file_sb;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // Index 0 drives the 4x32 instance, index 1 the 8x16 instance.
  logic        we    [2];
  logic [2:0]  wenc  [2];
  logic [31:0] wdata [2];
  logic [2:0]  renc0 [2];
  logic [2:0]  renc1 [2];
  logic        iv    [2];
  logic [2:0]  ienc  [2];

  logic [31:0] a_out0, a_out1, a_r0, a_r1;
  logic        a_hz0, a_hz1;
  logic [2:0]  a_cnt;
  logic [15:0] b_out0, b_out1, b_r0, b_r1;
  logic        b_hz0, b_hz1;
  logic [3:0]  b_cnt;

  reg_file_sb u_dut_a (
    .clk         (clk),
    .resetn      (resetn),
    .we          (we[0]),
    .r_write_enc (wenc[0][1:0]),
    .wdata       (wdata[0]),
    .r_enc_0     (renc0[0][1:0]),
    .r_enc_1     (renc1[0][1:0]),
    .reg_out_0   (a_out0),
    .reg_out_1   (a_out1),
    .issue_valid (iv[0]),
    .issue_enc   (ienc[0][1:0]),
    .hazard_0    (a_hz0),
    .hazard_1    (a_hz1),
    .pending_cnt (a_cnt),
    .R0_val      (a_r0),
    .R1_val      (a_r1)
  );

  reg_file_sb #(
    .DATA_W    (16),
    .NUM_REGS  (8),
    .RESET_VAL (16'h0003)
  ) u_dut_b (
    .clk         (clk),
    .resetn      (resetn),
    .we          (we[1]),
    .r_write_enc (wenc[1]),
    .wdata       (wdata[1][15:0]),
    .r_enc_0     (renc0[1]),
    .r_enc_1     (renc1[1]),
    .reg_out_0   (b_out0),
    .reg_out_1   (b_out1),
    .issue_valid (iv[1]),
    .issue_enc   (ienc[1]),
    .hazard_0    (b_hz0),
    .hazard_1    (b_hz1),
    .pending_cnt (b_cnt),
    .R0_val      (b_r0),
    .R1_val      (b_r1)
  );

  logic [31:0] o_rd0 [2];
  logic [31:0] o_rd1 [2];
  logic [31:0] o_hz0 [2];
  logic [31:0] o_hz1 [2];
  logic [31:0] o_cnt [2];
  logic [31:0] o_r0  [2];
  logic [31:0] o_r1  [2];

  always_comb begin
    o_rd0[0] = a_out0;             o_rd0[1] = {16'h0, b_out0};
    o_rd1[0] = a_out1;             o_rd1[1] = {16'h0, b_out1};
    o_hz0[0] = {31'h0, a_hz0};     o_hz0[1] = {31'h0, b_hz0};
    o_hz1[0] = {31'h0, a_hz1};     o_hz1[1] = {31'h0, b_hz1};
    o_cnt[0] = {29'h0, a_cnt};     o_cnt[1] = {28'h0, b_cnt};
    o_r0[0]  = a_r0;               o_r0[1]  = {16'h0, b_r0};
    o_r1[0]  = a_r1;               o_r1[1]  = {16'h0, b_r1};
  end

  // Behavioural model: register contents and pending flags per instance.
  logic [31:0] m_regs [2][8];
  logic        m_pend [2][8];
  logic        m_valid;
  int          tests;
  int          fails;

  function automatic int nregs(int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic logic [31:0] dmask(int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic logic [31:0] exp_read(int d, logic [2:0] e);
    if (ZR && e == 3'd0) return 32'd0;
    if (we[d] && wenc[d] == e) return wdata[d] & dmask(d);
    return m_regs[d][e];
  endfunction

  function automatic logic [31:0] exp_hazard(int d, logic [2:0] e);
    if (ZR && e == 3'd0) return 32'd0;
    if (we[d] && wenc[d] == e) return 32'd0;
    return {31'h0, m_pend[d][e]};
  endfunction

  function automatic logic [31:0] exp_count(int d);
    logic [31:0] c = 32'd0;
    for (int i = 0; i < nregs(d); i++) c = c + {31'h0, m_pend[d][i]};
    return c;
  endfunction

  task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL lit_%s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      check("reg_out_0", d, o_rd0[d], exp_read(d, renc0[d]));
      check("reg_out_1", d, o_rd1[d], exp_read(d, renc1[d]));
      check("hazard_0", d, o_hz0[d], exp_hazard(d, renc0[d]));
      check("hazard_1", d, o_hz1[d], exp_hazard(d, renc1[d]));
      check("pending_cnt", d, o_cnt[d], exp_count(d));
      check("R0_val", d, o_r0[d], ZR ? 32'd0 : m_regs[d][0]);
      check("R1_val", d, o_r1[d], m_regs[d][1]);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        for (int i = 0; i < 8; i++) begin
          m_regs[d][i] = (d == 0) ? 32'd0 : 32'd3;
          m_pend[d][i] = 1'b0;
        end
      end else begin
        if (we[d] && !(ZR && wenc[d] == 3'd0)) m_regs[d][wenc[d]] = wdata[d] & dmask(d);
        if (we[d]) m_pend[d][wenc[d]] = 1'b0;
        if (iv[d] && !(ZR && ienc[d] == 3'd0)) m_pend[d][ienc[d]] = 1'b1;
      end
    end
    if (!resetn) m_valid = 1'b1;
  endtask

  // Inputs are set at posedge+1; outputs are compared mid-cycle, then the model steps.
  task automatic tick();
    #2;
    if (m_valid) compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tests   = 0;
    fails   = 0;
    m_valid = 1'b0;

    // Reset held for two cycles against a live write and issue.
    resetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      we[d] = 1'b1; wenc[d] = 3'd0; wdata[d] = 32'd55;
      renc0[d] = 3'd0; renc1[d] = 3'd1; iv[d] = 1'b1; ienc[d] = 3'd0;
    end
    tick();
    tick();
    resetn = 1'b1;
    for (int d = 0; d < 2; d++) begin
      we[d] = 1'b0; iv[d] = 1'b0; wdata[d] = 32'd0;
    end
    #1;
    lit("rst_r0_a", o_r0[0], 32'd0);
    lit("rst_r1_a", o_r1[0], 32'd0);
    lit("rst_rd0_a", o_rd0[0], 32'd0);
    lit("rst_rd1_a", o_rd1[0], 32'd0);
    lit("rst_cnt_a", o_cnt[0], 32'd0);
    lit("rst_hz0_a", o_hz0[0], 32'd0);
    lit("rst_hz1_a", o_hz1[0], 32'd0);
    lit("rst_r0_b", o_r0[1], ZR ? 32'd0 : 32'd3);
    lit("rst_r1_b", o_r1[1], 32'd3);
    lit("rst_cnt_b", o_cnt[1], 32'd0);
    tick();
    for (int e = 0; e < 8; e++) begin
      renc0[1] = 3'(e);
      #1;
      lit("rst_rd_b", o_rd0[1], (ZR && e == 0) ? 32'd0 : 32'd3);
      tick();
    end

    // Write with same-cycle bypass, then a we=0 cycle that must not write.
    we[0] = 1'b1; wenc[0] = 3'd2; wdata[0] = 32'd10; renc0[0] = 3'd2;
    we[1] = 1'b1; wenc[1] = 3'd7; wdata[1] = 32'h0000_BEEF; renc0[1] = 3'd7;
    #1;
    lit("byp_a", o_rd0[0], 32'd10);
    lit("byp_b", o_rd0[1], 32'h0000_BEEF);
    tick();
    we[0] = 1'b0; wdata[0] = 32'd99;
    we[1] = 1'b0; wdata[1] = 32'h0000_1234;
    #1;
    lit("wr_a", o_rd0[0], 32'd10);
    lit("wr_b", o_rd0[1], 32'h0000_BEEF);
    lit("tap_r0_b", o_r0[1], ZR ? 32'd0 : 32'd3);
    lit("tap_r1_b", o_r1[1], 32'd3);
    tick();
    #1;
    lit("nowr_a", o_rd0[0], 32'd10);
    tick();

    // Scoreboard set, hazard, retire with bypass, clear.
    iv[0] = 1'b1; ienc[0] = 3'd1; renc1[0] = 3'd1;
    tick();
    iv[0] = 1'b0;
    #1;
    lit("sb_cnt1", o_cnt[0], 32'd1);
    lit("sb_hz1", o_hz1[0], 32'd1);
    we[0] = 1'b1; wenc[0] = 3'd1; wdata[0] = 32'd20;
    #1;
    lit("sb_hz1_byp", o_hz1[0], 32'd0);
    lit("sb_rd1_byp", o_rd1[0], 32'd20);
    tick();
    we[0] = 1'b0;
    #1;
    lit("sb_cnt0", o_cnt[0], 32'd0);
    lit("sb_rd1", o_rd1[0], 32'd20);
    tick();

    // Same-cycle issue and retire on a pending register: data lands, bit stays set.
    iv[0] = 1'b1; ienc[0] = 3'd3;
    tick();
    we[0] = 1'b1; wenc[0] = 3'd3; wdata[0] = 32'd7;
    tick();
    we[0] = 1'b0; iv[0] = 1'b0; renc0[0] = 3'd3;
    #1;
    lit("sim_cnt", o_cnt[0], 32'd1);
    lit("sim_rd", o_rd0[0], 32'd7);
    lit("sim_hz", o_hz0[0], 32'd1);
    tick();

    // Issue every register.
    for (int i = 0; i < 8; i++) begin
      iv[0] = 1'b1; ienc[0] = 3'(i % 4);
      iv[1] = 1'b1; ienc[1] = 3'(i);
      tick();
    end
    iv[0] = 1'b0; iv[1] = 1'b0;
    #1;
    lit("full_cnt_a", o_cnt[0], ZR ? 32'd3 : 32'd4);
    lit("full_cnt_b", o_cnt[1], ZR ? 32'd7 : 32'd8);
    tick();

    // Mid-operation reset drops all pending state.
    resetn = 1'b0; iv[0] = 1'b1; ienc[0] = 3'd2; iv[1] = 1'b1; ienc[1] = 3'd5;
    tick();
    resetn = 1'b1; iv[0] = 1'b0; iv[1] = 1'b0;
    #1;
    lit("mid_rst_cnt_a", o_cnt[0], 32'd0);
    lit("mid_rst_cnt_b", o_cnt[1], 32'd0);
    tick();

    // Write and issue enc 0 together.
    we[0] = 1'b1; wenc[0] = 3'd0; wdata[0] = 32'd5; iv[0] = 1'b1; ienc[0] = 3'd0;
    renc0[0] = 3'd0;
    #1;
    lit("zr_rd", o_rd0[0], ZR ? 32'd0 : 32'd5);
    lit("zr_hz", o_hz0[0], 32'd0);
    tick();
    we[0] = 1'b0; iv[0] = 1'b0;
    #1;
    lit("zr_cnt", o_cnt[0], ZR ? 32'd0 : 32'd1);
    lit("zr_r0", o_r0[0], ZR ? 32'd0 : 32'd5);
    lit("zr_hz_after", o_hz0[0], ZR ? 32'd0 : 32'd1);
    tick();

    // Mixed directed traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 24; i++) begin
      we[0]    = i[0];          wenc[0] = 3'((i * 3) % 4);
      wdata[0] = 32'hA5A5_0000 + 32'(i * 17);
      renc0[0] = 3'(i % 4);     renc1[0] = 3'((i + 1) % 4);
      iv[0]    = i[1];          ienc[0] = 3'((i * 5 + 1) % 4);
      we[1]    = ~i[0];         wenc[1] = 3'((i * 5) % 8);
      wdata[1] = 32'(i * 4099);
      renc0[1] = 3'((i * 3) % 8); renc1[1] = 3'((i * 5) % 8);
      iv[1]    = i[2] | i[0];   ienc[1] = 3'((i * 7 + 2) % 8);
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      we[d] = 1'b0; iv[d] = 1'b0;
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the 4-entry CPU register file, for the pipelined CPU decode/writeback stages.
- NUM_REGS x DATA_W registers; two combinational read ports and one write port.
- Write-to-read bypass on both read ports.
- Per-register pending-write scoreboard that raises read hazards for the pipeline stall logic.
- Debug taps for R0 and R1 kept for the board display.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 4, register count; power of two, >= 2
AW, $clog2(NUM_REGS), encoding width; derived, not overridden
RESET_VAL, 0, value loaded into every register on reset (DATA_W bits)

Ports:
clk  in  1  clock; all state updates on rising edge
resetn  in  1  synchronous active-low reset
we  in  1  writeback write enable
r_write_enc  in  AW  writeback destination register
wdata  in  DATA_W  writeback data
r_enc_0  in  AW  read port 0 select
r_enc_1  in  AW  read port 1 select
reg_out_0  out  DATA_W  read port 0 data
reg_out_1  out  DATA_W  read port 1 data
issue_valid  in  1  an instruction producing a register result is issuing
issue_enc  in  AW  destination of the issuing instruction
hazard_0  out  1  port 0 source has an outstanding, not-yet-bypassable write
hazard_1  out  1  port 1 source, same rule as hazard_0
pending_cnt  out  AW+1  number of registers with the pending bit set
R0_val  out  DATA_W  register 0 contents (debug)
R1_val  out  DATA_W  register 1 contents (debug)

Behaviour:
- Reset (resetn=0 at a rising edge):
  - every register <= RESET_VAL; every pending bit <= 0.
  - After reset: pending_cnt=0, hazard_0/1=0, R0_val=R1_val=RESET_VAL.
  - Reset overrides any same-cycle write or issue.
  - Reset asserted mid-operation discards all pending state in that cycle.
- Write: if we=1 at a rising edge, regs[r_write_enc] <= wdata. we=0 means no register change.
- Read: combinational.
  - reg_out_k = wdata when we=1 and r_write_enc==r_enc_k (bypass).
  - Otherwise reg_out_k = regs[r_enc_k].
  - Zero-cycle latency from a write to the value being visible.
- R0_val/R1_val: raw register contents, no bypass.
- Scoreboard, one bit per register, updated at the rising edge:
  - issue_valid=1 sets pending[issue_enc].
  - we=1 clears pending[r_write_enc].
  - Set and clear on the same register in the same cycle: set wins (the new producer supersedes the retiring one).
  - Issue to an already-pending register: bit stays 1. Writes are not counted; in-order writeback is guaranteed by the pipeline.
  - A write to a non-pending register is legal; it only updates data.
- Hazard: hazard_k = pending[r_enc_k] AND NOT (we AND r_write_enc==r_enc_k). A retiring write in the same cycle is covered by the bypass. Combinational.
- pending_cnt: registered popcount of the pending bits. Reflects state after the most recent edge, with the same timing as the pending bits. Maximum value NUM_REGS, hence AW+1 bits.
- No enc out-of-range cases: NUM_REGS is a power of two.

Optional Feature:
Macro: REG_FILE_ZERO_REG_EN
- Defined:
  - register 0 is hardwired to 0; writes to enc 0 are ignored.
  - reg_out_k=0 whenever r_enc_k=0, bypass included.
  - Issues to enc 0 never set pending; hazard_k=0 for enc 0.
  - R0_val=0 always.
- Undefined: register 0 is ordinary, exactly as described in Behaviour.

Test Plan:
- Reset: resetn=0 for 2 cycles with we=1, wdata=55 and issue_valid=1 held -> then R0_val=R1_val=0, all reg_out=0, pending_cnt=0, hazard_0/1=0.
- Write/bypass: we=1, r_write_enc=2, wdata=10, r_enc_0=2 in the same cycle -> reg_out_0=10 before the edge; after the edge with we=0, reg_out_0=10. With we=0, wdata=99 -> regs unchanged.
- Scoreboard: issue enc 1 -> next cycle pending_cnt=1, hazard_1=1 with r_enc_1=1. Cycle with we=1, r_write_enc=1, wdata=20 -> hazard_1=0, reg_out_1=20 same cycle; next cycle pending_cnt=0.
- Simultaneous: pending[3]=1, then issue_valid=1, issue_enc=3 and we=1, r_write_enc=3, wdata=7 in the same cycle -> reg3=7, pending[3] stays 1, pending_cnt unchanged. Issue to all 4 registers -> pending_cnt=4.
- Parametrised instance: NUM_REGS=8, DATA_W=16, RESET_VAL=16'h0003 -> reset reads 3 on enc 0..7. Write 16'hBEEF to enc 7 -> R0/R1 taps unaffected; pending_cnt reaches 8 after issuing all 8 registers.
- With REG_FILE_ZERO_REG_EN: write 5 to enc 0 and issue enc 0 -> reg_out_0=0, hazard_0=0, pending_cnt=0, R0_val=0.
